// File: rtl/noc_pkg.sv
// Shared NoC definitions: default widths, flit layout, network-interface FSM states.
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 64;
  localparam int NOC_COORD_BITS = 4;

  typedef struct packed {
    logic [NOC_COORD_BITS-1:0] dest_x;
    logic [NOC_COORD_BITS-1:0] dest_y;
    logic [NOC_DATA_WIDTH-1:0] data;
  } noc_flit_t;

  typedef enum logic {
    NI_IDLE  = 1'b0,
    NI_BURST = 1'b1
  } ni_state_t;

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry skid buffer: registered ready/valid on both sides, full throughput,
// output held stable while stalled. No combinational path out_ready -> in_ready.
module noc_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and pointers; these are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/noc_network_interface.sv
// Tile-side NoC endpoint: TX burst streaming into the router local port through
// a skid buffer, RX FWFT buffer from the router with misroute drop/flag.
module noc_network_interface
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = NOC_DATA_WIDTH,
  parameter int COORD_BITS    = NOC_COORD_BITS,
  parameter int NODE_X        = 0,
  parameter int NODE_Y        = 0,
  parameter int LEN_BITS      = 8,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_cmd_valid,
  output logic                  tx_cmd_ready,
  input  logic [COORD_BITS-1:0] tx_cmd_dest_x,
  input  logic [COORD_BITS-1:0] tx_cmd_dest_y,
  input  logic [LEN_BITS-1:0]   tx_cmd_beats_m1,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_data_valid,
  output logic                  tx_data_ready,
  output logic                  tx_done,
  output logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] noc_out_data,
  output logic [COORD_BITS-1:0] noc_out_dest_x,
  output logic [COORD_BITS-1:0] noc_out_dest_y,
  output logic                  noc_out_valid,
  input  logic                  noc_out_ready,
  input  logic [DATA_WIDTH-1:0] noc_in_data,
  input  logic [COORD_BITS-1:0] noc_in_dest_x,
  input  logic [COORD_BITS-1:0] noc_in_dest_y,
  input  logic                  noc_in_valid,
  output logic                  noc_in_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_misroute,
  output logic [31:0]           tx_flit_count,
  output logic [31:0]           rx_flit_count
);

  localparam int FLIT_W = 1 + 2 * COORD_BITS + DATA_WIDTH;
  localparam int PTR_W  = $clog2(RX_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(RX_FIFO_DEPTH);

  // ---------------- TX ----------------
  ni_state_t             state;
  ni_state_t             state_nxt;
  logic [LEN_BITS-1:0]   beats_left;
  logic [COORD_BITS-1:0] dest_x_q;
  logic [COORD_BITS-1:0] dest_y_q;
  logic                  beat_last;
  logic                  cmd_hs;
  logic                  tx_push;
  logic                  skid_in_ready;
  logic                  skid_out_valid;
  logic [FLIT_W-1:0]     skid_in;
  logic [FLIT_W-1:0]     skid_out;
  logic                  out_hs;

  assign beat_last = (beats_left == '0);
  assign cmd_hs    = tx_cmd_valid && tx_cmd_ready;
  assign tx_push   = tx_data_valid && tx_data_ready;
  assign skid_in   = {beat_last, dest_x_q, dest_y_q, tx_data};
  assign out_hs    = noc_out_valid && noc_out_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= NI_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; the last beat returns to IDLE so a new
  // command can only be taken the cycle after.
  always_comb begin
    state_nxt     = state;
    tx_cmd_ready  = 1'b0;
    tx_data_ready = 1'b0;
    case (state)
      NI_IDLE: begin
        tx_cmd_ready = 1'b1;
        if (tx_cmd_valid) state_nxt = NI_BURST;
      end
      NI_BURST: begin
        tx_data_ready = skid_in_ready;
        if (tx_data_valid && skid_in_ready && beat_last) state_nxt = NI_IDLE;
      end
      default: state_nxt = NI_IDLE;
    endcase
  end

  // Burst destination and beat down-counter, loaded on command acceptance.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      beats_left <= tx_cmd_beats_m1;
      dest_x_q   <= tx_cmd_dest_x;
      dest_y_q   <= tx_cmd_dest_y;
    end else if (tx_push) begin
      beats_left <= beats_left - 1'b1;
    end
  end

  noc_skid_buffer #(
    .WIDTH (FLIT_W)
  ) u_tx_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tx_push),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in),
    .out_valid (skid_out_valid),
    .out_ready (noc_out_ready),
    .out_data  (skid_out)
  );

  // Payload fields are zeroed while no flit is presented.
  assign noc_out_valid  = skid_out_valid;
  assign noc_out_data   = skid_out_valid ? skid_out[DATA_WIDTH-1:0] : '0;
  assign noc_out_dest_y = skid_out_valid ? skid_out[DATA_WIDTH +: COORD_BITS] : '0;
  assign noc_out_dest_x = skid_out_valid ? skid_out[DATA_WIDTH+COORD_BITS +: COORD_BITS] : '0;
  assign tx_busy        = (state == NI_BURST) || skid_out_valid;

  // Completion pulse after the router takes a last-tagged flit; TX flit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_done       <= 1'b0;
      tx_flit_count <= '0;
    end else begin
      tx_done <= out_hs && skid_out[FLIT_W-1];
      if (out_hs) tx_flit_count <= tx_flit_count + 32'd1;
    end
  end

  // ---------------- RX ----------------
  logic [DATA_WIDTH-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]      rx_wr_ptr;
  logic [PTR_W-1:0]      rx_rd_ptr;
  logic [CNT_W-1:0]      rx_count;
  logic                  in_hs;
  logic                  dest_hit;
  logic                  rx_push;
  logic                  rx_pop;

  assign noc_in_ready = (rx_count != RX_FULL);
  assign in_hs        = noc_in_valid && noc_in_ready;
  assign dest_hit     = (noc_in_dest_x == COORD_BITS'(NODE_X)) &&
                        (noc_in_dest_y == COORD_BITS'(NODE_Y));
  assign rx_push      = in_hs && dest_hit;
  assign rx_valid     = (rx_count != '0);
  assign rx_pop       = rx_valid && rx_ready;
  assign rx_data      = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  // RX occupancy, pointers, misroute flag and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      rx_misroute   <= 1'b0;
      rx_flit_count <= '0;
    end else begin
      rx_misroute <= in_hs && !dest_hit;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (rx_pop) rx_flit_count <= rx_flit_count + 32'd1;
    end
  end

  // RX payload storage.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= noc_in_data;
  end

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed bench for noc_network_interface at node (1,1).
module tb_noc_network_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_cmd_valid;
  logic        tx_cmd_ready;
  logic [3:0]  tx_cmd_dest_x;
  logic [3:0]  tx_cmd_dest_y;
  logic [7:0]  tx_cmd_beats_m1;
  logic [63:0] tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        tx_done;
  logic        tx_busy;
  logic [63:0] noc_out_data;
  logic [3:0]  noc_out_dest_x;
  logic [3:0]  noc_out_dest_y;
  logic        noc_out_valid;
  logic        noc_out_ready;
  logic [63:0] noc_in_data;
  logic [3:0]  noc_in_dest_x;
  logic [3:0]  noc_in_dest_y;
  logic        noc_in_valid;
  logic        noc_in_ready;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_misroute;
  logic [31:0] tx_flit_count;
  logic [31:0] rx_flit_count;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_done = 0;
  int done_at = -1;
  int n_mis  = 0;
  int drop_at;
  logic [63:0] fq_data[$];
  logic [7:0]  fq_dest[$];
  int          fq_cyc[$];
  logic [63:0] rq[$];

  always #5 clk = ~clk;

  noc_network_interface #(
    .DATA_WIDTH    (64),
    .COORD_BITS    (4),
    .NODE_X        (1),
    .NODE_Y        (1),
    .LEN_BITS      (8),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_cmd_valid    (tx_cmd_valid),
    .tx_cmd_ready    (tx_cmd_ready),
    .tx_cmd_dest_x   (tx_cmd_dest_x),
    .tx_cmd_dest_y   (tx_cmd_dest_y),
    .tx_cmd_beats_m1 (tx_cmd_beats_m1),
    .tx_data         (tx_data),
    .tx_data_valid   (tx_data_valid),
    .tx_data_ready   (tx_data_ready),
    .tx_done         (tx_done),
    .tx_busy         (tx_busy),
    .noc_out_data    (noc_out_data),
    .noc_out_dest_x  (noc_out_dest_x),
    .noc_out_dest_y  (noc_out_dest_y),
    .noc_out_valid   (noc_out_valid),
    .noc_out_ready   (noc_out_ready),
    .noc_in_data     (noc_in_data),
    .noc_in_dest_x   (noc_in_dest_x),
    .noc_in_dest_y   (noc_in_dest_y),
    .noc_in_valid    (noc_in_valid),
    .noc_in_ready    (noc_in_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_misroute     (rx_misroute),
    .tx_flit_count   (tx_flit_count),
    .rx_flit_count   (rx_flit_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (noc_out_valid && noc_out_ready) begin
        fq_data.push_back(noc_out_data);
        fq_dest.push_back({noc_out_dest_x, noc_out_dest_y});
        fq_cyc.push_back(cyc);
      end
      if (tx_done) begin
        n_done  = n_done + 1;
        done_at = fq_data.size();
      end
      if (rx_valid && rx_ready) rq.push_back(rx_data);
      if (rx_misroute) n_mis = n_mis + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] m1,
                            input logic [63:0] base, input int nbeats, output int drop);
    int i = 0;
    int t = 0;
    logic hs;
    drop = -1;
    tx_cmd_valid    = 1'b1;
    tx_cmd_dest_x   = dx;
    tx_cmd_dest_y   = dy;
    tx_cmd_beats_m1 = m1;
    check("cmd_ready_idle", {63'd0, tx_cmd_ready}, 64'd1);
    step();
    tx_cmd_valid = 1'b0;
    while (i < nbeats && t < 200) begin
      tx_data_valid = 1'b1;
      tx_data       = base + 64'(i);
      hs = tx_data_ready;
      if (!hs && drop < 0) drop = i;
      step();
      t++;
      if (hs) begin
        if (i == 0) check("first_flit_latency", {63'd0, noc_out_valid}, 64'd1);
        i++;
      end
    end
    tx_data_valid = 1'b0;
    if (t >= 200) check("burst_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_flits(input int n);
    int t = 0;
    while (fq_data.size() < n && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) check("flit_wait_timeout", 64'(fq_data.size()), 64'(n));
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    tx_cmd_valid = 1'b0; tx_cmd_dest_x = '0; tx_cmd_dest_y = '0; tx_cmd_beats_m1 = '0;
    tx_data = '0; tx_data_valid = 1'b0; noc_out_ready = 1'b1;
    noc_in_data = '0; noc_in_dest_x = '0; noc_in_dest_y = '0; noc_in_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    check("rst_cmd_ready", {63'd0, tx_cmd_ready}, 64'd1);
    check("rst_in_ready", {63'd0, noc_in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, noc_out_valid}, 64'd0);
    check("rst_busy", {63'd0, tx_busy}, 64'd0);
    check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("rst_tx_cnt", {32'd0, tx_flit_count}, 64'd0);
    check("rst_rx_cnt", {32'd0, rx_flit_count}, 64'd0);

    // 1: burst of 4 to (2,1) with router always ready
    send_burst(4'd2, 4'd1, 8'd3, 64'h1000, 4, drop_at);
    wait_flits(4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_data%0d", k), fq_data[k], 64'h1000 + 64'(k));
      check($sformatf("t1_dest%0d", k), {56'd0, fq_dest[k]}, 64'h21);
    end
    check("t1_back_to_back", 64'(fq_cyc[3] - fq_cyc[0]), 64'd3);
    check("t1_done_count", 64'(n_done), 64'd1);
    check("t1_done_after_last", 64'(done_at), 64'd4);
    check("t1_tx_cnt", {32'd0, tx_flit_count}, 64'd4);
    check("t1_busy_idle", {63'd0, tx_busy}, 64'd0);

    // 2: same burst, router stalls for 5 cycles after the first flit
    fq_data.delete(); fq_dest.delete(); fq_cyc.delete();
    n_done = 0; done_at = -1;
    fork
      send_burst(4'd2, 4'd1, 8'd3, 64'h1000, 4, drop_at);
      begin
        int t = 0;
        @(negedge clk);
        while (!noc_out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #1;
        noc_out_ready = 1'b0;
        repeat (5) step();
        noc_out_ready = 1'b1;
      end
    join
    wait_flits(4);
    check("t2_ready_drop_beat", 64'(drop_at), 64'd3);
    check("t2_flit_count", 64'(fq_data.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t2_data%0d", k), fq_data[k], 64'h1000 + 64'(k));
    check("t2_done_count", 64'(n_done), 64'd1);
    check("t2_done_after_last", 64'(done_at), 64'd4);
    check("t2_tx_cnt", {32'd0, tx_flit_count}, 64'd8);

    // 3: single local RX flit
    rq.delete();
    noc_in_valid = 1'b1; noc_in_data = 64'hFEDCBA98_76543210;
    noc_in_dest_x = 4'd1; noc_in_dest_y = 4'd1;
    step();
    noc_in_valid = 1'b0;
    check("t3_rx_valid", {63'd0, rx_valid}, 64'd1);
    check("t3_rx_data", rx_data, 64'hFEDCBA98_76543210);
    check("t3_no_misroute", {63'd0, rx_misroute}, 64'd0);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("t3_rx_drained", {63'd0, rx_valid}, 64'd0);
    check("t3_rx_cnt", {32'd0, rx_flit_count}, 64'd1);
    check("t3_delivered", 64'(rq.size()), 64'd1);

    // 4: fill RX buffer with tile stalled, then drain
    rq.delete();
    for (int k = 0; k < 4; k++) begin
      noc_in_valid = 1'b1; noc_in_data = 64'hA0 + 64'(k);
      step();
    end
    check("t4_full_in_ready", {63'd0, noc_in_ready}, 64'd0);
    noc_in_data = 64'hA4;
    rx_ready = 1'b1;
    begin
      int t = 0;
      logic hs = 1'b0;
      while (!hs && t < 20) begin
        hs = noc_in_ready;
        step();
        t++;
      end
      if (!hs) check("t4_push_timeout", 64'd0, 64'd1);
    end
    noc_in_valid = 1'b0;
    begin
      int t = 0;
      while (rq.size() < 5 && t < 30) begin
        step();
        t++;
      end
    end
    rx_ready = 1'b0;
    check("t4_delivered", 64'(rq.size()), 64'd5);
    for (int k = 0; k < 5 && k < rq.size(); k++)
      check($sformatf("t4_data%0d", k), rq[k], 64'hA0 + 64'(k));
    check("t4_rx_cnt", {32'd0, rx_flit_count}, 64'd6);

    // 5: misrouted flit is dropped and flagged once
    n_mis = 0;
    noc_in_valid = 1'b1; noc_in_data = 64'h55; noc_in_dest_x = 4'd3; noc_in_dest_y = 4'd0;
    step();
    noc_in_valid = 1'b0;
    check("t5_misroute_pulse", {63'd0, rx_misroute}, 64'd1);
    check("t5_no_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("t5_in_ready", {63'd0, noc_in_ready}, 64'd1);
    step();
    check("t5_misroute_clear", {63'd0, rx_misroute}, 64'd0);
    check("t5_misroute_count", 64'(n_mis), 64'd1);
    check("t5_rx_cnt", {32'd0, rx_flit_count}, 64'd6);

    // 6: reset in the middle of a burst
    n_done = 0;
    send_burst(4'd0, 4'd0, 8'd3, 64'h2000, 2, drop_at);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_out_valid", {63'd0, noc_out_valid}, 64'd0);
    check("t6_busy", {63'd0, tx_busy}, 64'd0);
    check("t6_cmd_ready", {63'd0, tx_cmd_ready}, 64'd1);
    check("t6_tx_cnt", {32'd0, tx_flit_count}, 64'd0);
    check("t6_rx_cnt", {32'd0, rx_flit_count}, 64'd0);
    repeat (5) step();
    check("t6_no_done", 64'(n_done), 64'd0);
    check("t6_still_idle", {63'd0, noc_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
